// File: rtl/mem_write_checker.sv
// Store-stream checker for the MIPS data-memory write port: compares stores against a loaded
// table of expected (address, data) pairs and reports a sticky PASS/FAIL verdict.
module mem_write_checker #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IGNORE_EN   = 1,
  parameter int unsigned IGNORE_ADDR = 80,
  parameter int unsigned TIMEOUT     = 1000,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_exp_load,
  input  logic [ADDR_W-1:0] i_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
  input  logic              i_start,
  input  logic              i_memwrite,
  input  logic [ADDR_W-1:0] i_dataadr,
  input  logic [DATA_W-1:0] i_writedata,
  output logic              o_done,
  output logic              o_pass,
  output logic [1:0]        o_fail_code,
  output logic [CW-1:0]     o_match_count,
  output logic [7:0]        o_ignore_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic [CW-1:0]     r_idx, w_idx_nxt;
  logic [7:0]        r_ign, w_ign_nxt;
  logic [WW-1:0]     r_wd, w_wd_nxt;
  logic [1:0]        r_code, w_code_nxt;
  logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
  logic [DATA_W-1:0] r_fail_data, w_fail_data_nxt;

  // Table needs no reset: entries at or above r_count are never read.
  logic [ADDR_W-1:0] r_tab_addr [DEPTH];
  logic [DATA_W-1:0] r_tab_data [DEPTH];

  logic          w_full;
  logic          w_load_ok;
  logic [CW-1:0] w_count_upd;
  logic          w_ovf_upd;
  logic          w_hit;
  logic          w_ign_addr;
  logic [CW-1:0] w_idx_inc;
  logic          w_wd_expired;

  always_comb begin
    w_full       = (r_count == CW'(DEPTH));
    w_load_ok    = i_exp_load && !w_full;
    w_count_upd  = w_load_ok ? r_count + 1'b1 : r_count;
    w_ovf_upd    = r_ovf || (i_exp_load && w_full);
    w_hit        = i_memwrite
                   && (i_dataadr == r_tab_addr[r_idx[IW-1:0]])
                   && (i_writedata == r_tab_data[r_idx[IW-1:0]]);
    w_ign_addr   = (IGNORE_EN != 0) && (i_dataadr == ADDR_W'(IGNORE_ADDR));
    w_idx_inc    = r_idx + 1'b1;
    w_wd_expired = (TIMEOUT != 0) && (r_wd == WW'(TIMEOUT));
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_ovf_nxt       = r_ovf;
    w_idx_nxt       = r_idx;
    w_ign_nxt       = r_ign;
    w_wd_nxt        = r_wd;
    w_code_nxt      = r_code;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_data_nxt = r_fail_data;
    if (i_clear) begin
      w_state_nxt     = StIdle;
      w_count_nxt     = '0;
      w_ovf_nxt       = 1'b0;
      w_idx_nxt       = '0;
      w_ign_nxt       = '0;
      w_wd_nxt        = '0;
      w_code_nxt      = 2'd0;
      w_fail_addr_nxt = '0;
      w_fail_data_nxt = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_count_nxt = w_count_upd;
          w_ovf_nxt   = w_ovf_upd;
          // Start decision sees the load applied in the same cycle.
          if (i_start) begin
            if (w_ovf_upd) begin
              w_state_nxt = StFail;
              w_code_nxt  = 2'd3;
            end else if (w_count_upd == '0) begin
              w_state_nxt = StPass;
            end else begin
              w_state_nxt = StRun;
              w_idx_nxt   = '0;
              w_wd_nxt    = '0;
            end
          end
        end
        StRun: begin
          if (w_hit) begin
            w_idx_nxt = w_idx_inc;
            w_wd_nxt  = '0;
            if (w_idx_inc == r_count) w_state_nxt = StPass;
          end else if (i_memwrite && !w_ign_addr) begin
            w_state_nxt     = StFail;
            w_code_nxt      = 2'd1;
            w_fail_addr_nxt = i_dataadr;
            w_fail_data_nxt = i_writedata;
          end else begin
            if (i_memwrite && (r_ign != 8'hFF)) w_ign_nxt = r_ign + 8'd1;
            if (w_wd_expired) begin
              w_state_nxt = StFail;
              w_code_nxt  = 2'd2;
            end else if (TIMEOUT != 0) begin
              w_wd_nxt = r_wd + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
      r_ign       <= '0;
      r_wd        <= '0;
      r_code      <= 2'd0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      r_idx       <= w_idx_nxt;
      r_ign       <= w_ign_nxt;
      r_wd        <= w_wd_nxt;
      r_code      <= w_code_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_data <= w_fail_data_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == StIdle && !i_clear && w_load_ok) begin
      r_tab_addr[r_count[IW-1:0]] <= i_exp_addr;
      r_tab_data[r_count[IW-1:0]] <= i_exp_data;
    end
  end

  always_comb begin
    o_done         = (r_state == StPass) || (r_state == StFail);
    o_pass         = (r_state == StPass);
    o_fail_code    = r_code;
    o_match_count  = r_idx;
    o_ignore_count = r_ign;
    o_fail_addr    = r_fail_addr;
    o_fail_data    = r_fail_data;
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two instances (DEPTH=4/TIMEOUT=20 and DEPTH=8/TIMEOUT=0)
// share stimulus and are compared every cycle against an event-level reference model.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, exp_load, start, memwrite;
  logic [31:0] exp_addr, exp_data, dataadr, writedata;

  logic [1:0]  done, pass;
  logic [1:0]  code_a, code_b;
  logic [2:0]  mc_a;
  logic [3:0]  mc_b;
  logic [7:0]  ign_a, ign_b;
  logic [31:0] fa_a, fa_b, fd_a, fd_b;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.DEPTH(4), .TIMEOUT(20)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clear), .i_exp_load(exp_load),
    .i_exp_addr(exp_addr), .i_exp_data(exp_data), .i_start(start), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(writedata), .o_done(done[0]), .o_pass(pass[0]),
    .o_fail_code(code_a), .o_match_count(mc_a), .o_ignore_count(ign_a),
    .o_fail_addr(fa_a), .o_fail_data(fd_a)
  );

  mem_write_checker #(.DEPTH(8), .TIMEOUT(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clear), .i_exp_load(exp_load),
    .i_exp_addr(exp_addr), .i_exp_data(exp_data), .i_start(start), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(writedata), .o_done(done[1]), .o_pass(pass[1]),
    .o_fail_code(code_b), .o_match_count(mc_b), .o_ignore_count(ign_b),
    .o_fail_addr(fa_b), .o_fail_data(fd_b)
  );

  // Reference model. Status: 0 idle, 1 checking, 2 passed, 3 failed.
  int          m_depth [2] = '{4, 8};
  int          m_to    [2] = '{20, 0};
  int          m_st    [2];
  int          m_cnt   [2];
  int          m_ovf   [2];
  int          m_idx   [2];
  int          m_ign   [2];
  int          m_last  [2];
  int          m_code  [2];
  logic [31:0] m_fa    [2];
  logic [31:0] m_fd    [2];
  logic [31:0] m_ta    [2][8];
  logic [31:0] m_td    [2][8];
  int          edge_no = 0;

  task automatic model_zero(input int k);
    m_st[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_idx[k] = 0; m_ign[k] = 0;
    m_last[k] = 0; m_code[k] = 0; m_fa[k] = 0; m_fd[k] = 0;
  endtask

  task automatic model_step(input int k);
    if (clear) begin
      model_zero(k);
      return;
    end
    if (m_st[k] == 0) begin
      if (exp_load) begin
        if (m_cnt[k] < m_depth[k]) begin
          m_ta[k][m_cnt[k]] = exp_addr;
          m_td[k][m_cnt[k]] = exp_data;
          m_cnt[k]++;
        end else m_ovf[k] = 1;
      end
      if (start) begin
        if (m_ovf[k] != 0) begin m_st[k] = 3; m_code[k] = 3; end
        else if (m_cnt[k] == 0) m_st[k] = 2;
        else begin m_st[k] = 1; m_idx[k] = 0; m_last[k] = edge_no; end
      end
    end else if (m_st[k] == 1) begin
      if (memwrite && dataadr == m_ta[k][m_idx[k]] && writedata == m_td[k][m_idx[k]]) begin
        m_idx[k]++;
        m_last[k] = edge_no;
        if (m_idx[k] == m_cnt[k]) m_st[k] = 2;
      end else if (memwrite && dataadr != 32'd80) begin
        m_st[k] = 3; m_code[k] = 1; m_fa[k] = dataadr; m_fd[k] = writedata;
      end else begin
        if (memwrite && m_ign[k] < 255) m_ign[k]++;
        // Quiet for TIMEOUT+1 edges since entry or last match.
        if (m_to[k] != 0 && edge_no - m_last[k] == m_to[k] + 1) begin
          m_st[k] = 3; m_code[k] = 2;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.done", 32'(done[0]), 32'(m_st[0] >= 2));
    chk("a.pass", 32'(pass[0]), 32'(m_st[0] == 2));
    chk("a.code", 32'(code_a), 32'(m_code[0]));
    chk("a.match", 32'(mc_a), 32'(m_idx[0]));
    chk("a.ignore", 32'(ign_a), 32'(m_ign[0]));
    chk("a.faddr", fa_a, m_fa[0]);
    chk("a.fdata", fd_a, m_fd[0]);
    chk("b.done", 32'(done[1]), 32'(m_st[1] >= 2));
    chk("b.pass", 32'(pass[1]), 32'(m_st[1] == 2));
    chk("b.code", 32'(code_b), 32'(m_code[1]));
    chk("b.match", 32'(mc_b), 32'(m_idx[1]));
    chk("b.ignore", 32'(ign_b), 32'(m_ign[1]));
    chk("b.faddr", fa_b, m_fa[1]);
    chk("b.fdata", fd_b, m_fd[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    edge_no++;
    model_step(0);
    model_step(1);
    check_all();
    @(negedge clk);
    clear = 0; exp_load = 0; start = 0; memwrite = 0;
  endtask

  task automatic do_clear();
    clear = 1; cyc();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    exp_load = 1; exp_addr = a; exp_data = d; cyc();
  endtask

  task automatic do_start();
    start = 1; cyc();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d; cyc();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd4;
      2: return 32'd8;
      3: return 32'd80;
      default: return 32'd84;
    endcase
  endfunction

  initial begin
    rst_n = 0; clear = 0; exp_load = 0; start = 0; memwrite = 0;
    exp_addr = 0; exp_data = 0; dataadr = 0; writedata = 0;
    model_zero(0);
    model_zero(1);
    @(negedge clk);
    check_all();
    rst_n = 1;
    @(negedge clk);

    // Scratch stores tolerated, then the expected store passes.
    do_load(84, 7); do_start();
    do_store(80, 3); do_store(80, 5); do_store(84, 7);
    chk("tp1.pass", 32'(pass[0]), 1);
    chk("tp1.ignore", 32'(ign_a), 2);
    chk("tp1.match", 32'(mc_a), 1);

    // Wrong address fails; later correct store does not change the verdict.
    do_clear(); do_load(84, 7); do_start(); do_store(88, 7);
    chk("tp2.code", 32'(code_a), 1);
    chk("tp2.faddr", fa_a, 88);
    do_store(84, 7);
    chk("tp2.sticky", 32'(code_a), 1);
    chk("tp2.sticky_data", fd_a, 7);

    // Watchdog: quiet for 20 edges stays in RUN, 21st edge fails.
    do_clear(); do_load(0, 1); do_start();
    for (int i = 0; i < 20; i++) cyc();
    chk("tp3.not_yet", 32'(done[0]), 0);
    cyc();
    chk("tp3.timeout_done", 32'(done[0]), 1);
    chk("tp3.timeout_code", 32'(code_a), 2);
    for (int i = 0; i < 480; i++) cyc();
    chk("tp3.no_wd_done", 32'(done[1]), 0);

    // Overflow on the 4-deep table; empty table passes at once.
    do_clear();
    for (int i = 0; i < 5; i++) do_load(32'(4 * i), 32'(i));
    do_start();
    chk("tp4.ovf_code", 32'(code_a), 3);
    do_clear(); do_start();
    chk("tp4.empty_pass", 32'(pass[0]), 1);

    // Out-of-order store fails after one match.
    do_clear(); do_load(0, 1); do_load(4, 2); do_load(8, 3); do_start();
    do_store(0, 1); do_store(8, 3);
    chk("tp5.code", 32'(code_a), 1);
    chk("tp5.match", 32'(mc_a), 1);

    // clear beats start in the same cycle.
    do_clear(); do_load(84, 7);
    clear = 1; start = 1; cyc();
    chk("clr_start.done", 32'(done[0]), 0);

    // Ignore counter saturates (instance B has no watchdog).
    do_load(84, 7); do_start();
    for (int i = 0; i < 260; i++) do_store(80, 1);
    chk("sat.ignore", 32'(ign_b), 255);

    // Asynchronous reset mid-RUN, then a clean rerun.
    do_clear(); do_load(0, 1); do_load(4, 2); do_start(); do_store(0, 1);
    #2 rst_n = 0;
    #1;
    model_zero(0);
    model_zero(1);
    check_all();
    @(negedge clk);
    rst_n = 1;
    do_load(0, 1); do_load(4, 2); do_start(); do_store(0, 1); do_store(4, 2);
    chk("rst.rerun_pass", 32'(pass[0]), 1);

    // Randomised sessions, including a load fused with start.
    for (int it = 0; it < 40; it++) begin
      int n;
      bit fused;
      do_clear();
      n = $urandom_range(0, 5);
      fused = 1'b0;
      for (int i = 0; i < n; i++) begin
        exp_load = 1; exp_addr = pick_addr(); exp_data = $urandom_range(0, 3);
        if (i == n - 1 && $urandom_range(0, 1) == 1) begin
          start = 1; fused = 1'b1;
        end
        cyc();
      end
      if (!fused) do_start();
      for (int j = 0; j < 25; j++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 50 && m_st[0] == 1) do_store(m_ta[0][m_idx[0]], m_td[0][m_idx[0]]);
        else if (r < 65) do_store(80, $urandom_range(0, 3));
        else if (r < 75) do_store(pick_addr(), $urandom_range(0, 3));
        else cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised self-checking monitor for the single-cycle MIPS data-memory write port. It sits beside `top` on the `memwrite`/`dataadr`/`writedata` bus. It compares every store against a programmed table of expected (address, data) pairs, tolerates stores to one scratch address, and enforces a watchdog. It reports a sticky pass/fail verdict with a failure code and the offending store, so the same checker serves simulation benches and FPGA bring-up.

## Interface
- `ADDR_W`, 32, width of `dataadr` and table addresses
- `DATA_W`, 32, width of `writedata` and table data
- `DEPTH`, 8, number of expected-store table entries (≥1)
- `IGNORE_EN`, 1, when 1, stores to `IGNORE_ADDR` that do not match are skipped instead of failing
- `IGNORE_ADDR`, 80, tolerated scratch address
- `TIMEOUT`, 1000, max cycles in RUN without a matching store; 0 disables the watchdog
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous return to IDLE, empties table
- `exp_load`  in  1  append (`exp_addr`, `exp_data`) to table
- `exp_addr`  in  ADDR_W  expected store address
- `exp_data`  in  DATA_W  expected store data
- `start`  in  1  begin checking
- `memwrite`  in  1  store strobe from processor
- `dataadr`  in  ADDR_W  store address
- `writedata`  in  DATA_W  store data
- `done`  out  1  verdict reached (PASS or FAIL)
- `pass`  out  1  all expected stores seen in order
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout, 3 table overflow at start
- `match_count`  out  clog2(DEPTH+1)  expected stores matched so far
- `ignore_count`  out  8  tolerated scratch stores, saturating at 255
- `fail_addr`  out  ADDR_W  address of failing store (0 on timeout)
- `fail_data`  out  DATA_W  data of failing store (0 on timeout)

## Operation
- States: IDLE, RUN, PASS, FAIL. `done`=1 in PASS/FAIL. `pass`=1 only in PASS.
- IDLE: `exp_load` writes entry[`count`] and increments `count`. A load when `count`==DEPTH is dropped and sets a sticky `ovf` flag. `memwrite` is ignored.
- IDLE + `start`: if `ovf`, go to FAIL with code 3. Else if `count`==0, go to PASS. Else go to RUN with `idx`=0 and watchdog=0.
- `exp_load` and `start` in the same cycle: the load is applied first, and the start decision uses the updated `count`/`ovf`.
- RUN, on `memwrite`=1 with `dataadr`==entry[`idx`].addr and `writedata`==entry[`idx`].data: increment `idx`/`match_count` and clear the watchdog. If new `idx`==`count`, go to PASS.
- RUN, on `memwrite`=1 with any other store:
  - If IGNORE_EN and `dataadr`==IGNORE_ADDR: increment `ignore_count` (saturating). The watchdog is not cleared.
  - Otherwise: go to FAIL, code 1, and latch `fail_addr`/`fail_data`.
- A matching store to IGNORE_ADDR counts as a match, not an ignore.
- RUN, no matching store: the watchdog increments each cycle. When TIMEOUT≠0 and the watchdog reaches TIMEOUT, go to FAIL with code 2.
- `exp_load` and `start` are ignored outside IDLE. Stores in PASS/FAIL are ignored, and the verdict is sticky.
- `clear` from any state: go to IDLE. Zero `count`, `ovf`, `idx`, `match_count`, `ignore_count`, `fail_*`, `fail_code`. If `clear` and `start` arrive together, `clear` wins.
- Width rules: the watchdog is clog2(TIMEOUT+1) bits and never wraps. Comparisons are full-width equality.

## Timing
- `reset` low (async, any state, mid-RUN included): state IDLE, and all outputs and counters 0. The table contents need no reset, since `count`=0.
- Inputs are sampled on the rising edge. Verdict outputs update 1 cycle after the deciding store/start/watchdog edge. There is no combinational path from inputs to outputs.
- `start` → RUN is visible the next cycle. A store on that same cycle as `start` is not checked.
- Timeout: FAIL is asserted exactly TIMEOUT+1 edges after entering RUN, or after the last match, when no match occurs.
- Back-to-back stores on consecutive cycles are each checked; there is no throughput limit.

## Test plan
- Load (84,7); start; stores (80,3),(80,5),(84,7) → `ignore_count`=2, PASS one cycle after the third store, `match_count`=1.
- Load (84,7); start; store (88,7) → FAIL, `fail_code`=1, `fail_addr`=88, `fail_data`=7; a later (84,7) leaves the verdict unchanged.
- TIMEOUT=20, load one entry, start, no stores → `done`=1 with code 2 exactly 21 cycles after RUN entry; repeat with TIMEOUT=0 for 500 cycles → still RUN.
- DEPTH=4: load 5 entries, start → FAIL code 3; `clear`, load 0 entries, start → PASS next cycle.
- Ordered sequence (0,1),(4,2),(8,3), with the second store sent as (8,3) → FAIL code 1 at `match_count`=1.
- Assert `reset` low mid-RUN after one match → all outputs 0 immediately; after release, reload and rerun to PASS.
